prng_stream_checker: RTL and testbench

Receiving-end companion to the 21-bit XOR-shift random generator. It consumes the generator's 7-bit sample stream under a valid qualifier and reconstructs the full 21-bit generator state from consecutive samples. Once it has the state, it predicts every following sample and flags divergence. It sits between the generator and the game logic as a link and sequence integrity monitor.

---
 rtl/prng_pkg.sv | 18 +
 rtl/prng_next_state.sv | 15 +
 rtl/prng_stream_checker.sv | 127 ++++++++++++
 tb/tb_prng_stream_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared constants and state type for the 21-bit XOR-shift generator and its stream checker.
package prng_pkg;

    localparam int unsigned LFSR_W   = 21;
    localparam int unsigned SAMPLE_W = 7;

    // Feedback taps: new bit 1 = S[20]^S[10], new bit 0 = S[0]^S[5]
    localparam int unsigned TAP_A_HI = 20;
    localparam int unsigned TAP_A_LO = 10;
    localparam int unsigned TAP_B_HI = 0;
    localparam int unsigned TAP_B_LO = 5;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } chk_state_e;

endpackage

// File: rtl/prng_next_state.sv
// Combinational generator step: next(S) and the sample that next state will emit.
module prng_next_state
    import prng_pkg::*;
(
    input  logic [LFSR_W-1:0]   state,
    output logic [LFSR_W-1:0]   next_state,
    output logic [SAMPLE_W-1:0] next_sample
);

    assign next_state  = {state[LFSR_W-3:0],
                          state[TAP_A_HI] ^ state[TAP_A_LO],
                          state[TAP_B_HI] ^ state[TAP_B_LO]};
    assign next_sample = next_state[SAMPLE_W-1:0];

endmodule

// File: rtl/prng_stream_checker.sv
// Rebuilds the generator state from its 7-bit sample stream, then predicts and checks each sample.
// Define PRNG_CHECK_STATS_EN to build the saturating err_count register; otherwise it reads 0.
module prng_stream_checker
    import prng_pkg::*;
#(
    parameter int ERR_W      = 8,
    parameter int MISS_LIMIT = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                locked,
    output logic [SAMPLE_W-1:0] expected,
    output logic                mismatch,
    output logic [ERR_W-1:0]    err_count
);

    localparam logic [2:0] ACQ_LAST = 3'd7;

    chk_state_e          st_q, st_d;
    logic [LFSR_W-1:0]   shadow_q, shadow_d;
    logic [SAMPLE_W-1:0] prev_q, prev_d;
    logic [2:0]          acq_cnt_q, acq_cnt_d;
    logic [3:0]          miss_cnt_q, miss_cnt_d;
    logic                mismatch_q, mismatch_d;

    logic [LFSR_W-1:0]   pred_state;
    logic [SAMPLE_W-1:0] pred_sample;
    logic [3:0]          miss_inc;

    prng_next_state u_next (
        .state       (shadow_q),
        .next_state  (pred_state),
        .next_sample (pred_sample)
    );

    assign miss_inc = miss_cnt_q + 4'd1;

    always_comb begin
        st_d       = st_q;
        shadow_d   = shadow_q;
        prev_d     = prev_q;
        acq_cnt_d  = acq_cnt_q;
        miss_cnt_d = miss_cnt_q;
        mismatch_d = 1'b0;
        if (sample_valid) begin
            unique case (st_q)
                ACQUIRE: begin
                    prev_d = sample;
                    // A sample that doesn't continue the previous one restarts acquisition on itself
                    if (acq_cnt_q == 3'd0 || sample[6:2] != prev_q[4:0]) begin
                        shadow_d[SAMPLE_W-1:0] = sample;
                        acq_cnt_d              = 3'd1;
                    end else begin
                        shadow_d = {shadow_q[LFSR_W-3:0], sample[1:0]};
                        if (acq_cnt_q == ACQ_LAST) begin
                            st_d       = LOCKED;
                            miss_cnt_d = 4'd0;
                            acq_cnt_d  = 3'd0;
                        end else begin
                            acq_cnt_d = acq_cnt_q + 3'd1;
                        end
                    end
                end
                LOCKED: begin
                    shadow_d = pred_state;
                    if (sample == pred_sample) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        mismatch_d = 1'b1;
                        miss_cnt_d = miss_inc;
                        if (miss_inc == 4'(MISS_LIMIT)) begin
                            st_d                   = ACQUIRE;
                            shadow_d[SAMPLE_W-1:0] = sample;
                            prev_d                 = sample;
                            acq_cnt_d              = 3'd1;
                            miss_cnt_d             = 4'd0;
                        end
                    end
                end
                default: st_d = ACQUIRE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q       <= ACQUIRE;
            shadow_q   <= '0;
            prev_q     <= '0;
            acq_cnt_q  <= '0;
            miss_cnt_q <= '0;
            mismatch_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            shadow_q   <= shadow_d;
            prev_q     <= prev_d;
            acq_cnt_q  <= acq_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            mismatch_q <= mismatch_d;
        end
    end

`ifdef PRNG_CHECK_STATS_EN
    logic [ERR_W-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (mismatch_d && err_q != '1) err_d = err_q + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err_q <= '0;
        else         err_q <= err_d;
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

    assign locked   = (st_q == LOCKED);
    assign mismatch = mismatch_q;
    assign expected = locked ? pred_sample : '0;

endmodule

// File: tb/tb_prng_stream_checker.sv
// Directed bench for prng_stream_checker: table-driven lock/track vectors plus corner-case sequences.
module tb_prng_stream_checker;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       sample_valid = 1'b0;
    logic [6:0] sample = '0;
    logic       locked;
    logic [6:0] expected;
    logic       mismatch;
    logic [7:0] err_count;

    prng_stream_checker #(.ERR_W(8), .MISS_LIMIT(3)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sample_valid (sample_valid),
        .sample       (sample),
        .locked       (locked),
        .expected     (expected),
        .mismatch     (mismatch),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

`ifdef PRNG_CHECK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic [6:0] s;
        logic       lk;
        logic       mm;
        logic       chk_exp;
    } vec_t;

    vec_t        tbl[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          mm_seen = 0;
    int          n_err   = 0;
    logic [20:0] g;

    function automatic logic [20:0] nx(input logic [20:0] s);
        return {s[18:0], s[20] ^ s[10], s[0] ^ s[5]};
    endfunction

    function automatic int err_exp(input int n);
        return STATS ? ((n > 255) ? 255 : n) : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [6:0] s);
        sample_valid = v;
        sample       = s;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        mm_seen += int'(mismatch);
    endtask

    task automatic good();
        logic [6:0] s;
        s = g[6:0];
        g = nx(g);
        step(1'b1, s);
    endtask

    task automatic bad(input bit zero_sub);
        logic [6:0] s;
        s = g[6:0];
        g = nx(g);
        if (zero_sub && s != 7'h00) step(1'b1, 7'h00);
        else                        step(1'b1, s ^ 7'h7F);
        n_err++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_err   = 0;
        mm_seen = 0;
    endtask

    function automatic void push(input logic v, input logic lk, input logic chk_e);
        vec_t e;
        e.v = v;
        e.lk = lk;
        e.mm = 1'b0;
        e.chk_exp = chk_e;
        if (v) begin
            e.s = g[6:0];
            g = nx(g);
        end else begin
            e.s = 7'h00;
        end
        tbl.push_back(e);
    endfunction

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_expected", int'(expected), 0);
        @(negedge clk);
        resetn = 1'b1;

        // seed 1FFFFF: 8 samples lock, then tracking with idle gaps carrying junk data
        g = 21'h1FFFFF;
        for (int i = 0; i < 8; i++) push(1'b1, (i == 7), 1'b0);
        push(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 1'b1);
        push(1'b0, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b1);
        chk("seed_s1", int'(tbl[1].s), 'h7C);
        chk("seed_s2", int'(tbl[2].s), 'h71);
        foreach (tbl[i]) begin
            if (tbl[i].chk_exp) chk($sformatf("tbl_expected[%0d]", i), int'(expected), int'(tbl[i].s));
            step(tbl[i].v, tbl[i].s);
            chk($sformatf("tbl_locked[%0d]", i), int'(locked), int'(tbl[i].lk));
            chk($sformatf("tbl_mismatch[%0d]", i), int'(mismatch), int'(tbl[i].mm));
        end

        // single zero substitution while locked
        bad(1'b1);
        chk("one_bad_mm", int'(mismatch), 1);
        chk("one_bad_locked", int'(locked), 1);
        chk("one_bad_err", int'(err_count), err_exp(n_err));
        for (int i = 0; i < 4; i++) begin
            good();
            chk("one_bad_recover_mm", int'(mismatch), 0);
        end
        chk("one_bad_err_hold", int'(err_count), err_exp(n_err));

        // MISS_LIMIT consecutive corruptions drop lock; eight correct samples relock
        for (int i = 0; i < 3; i++) begin
            bad(1'b0);
            chk($sformatf("miss_mm[%0d]", i), int'(mismatch), 1);
            chk($sformatf("miss_locked[%0d]", i), int'(locked), (i < 2) ? 1 : 0);
        end
        chk("miss_err", int'(err_count), err_exp(n_err));
        for (int i = 0; i < 8; i++) begin
            good();
            chk($sformatf("relock[%0d]", i), int'(locked), (i == 7) ? 1 : 0);
        end
        chk("relock_expected", int'(expected), int'(g[6:0]));
        good();
        chk("relock_track_mm", int'(mismatch), 0);

        // continuity break during acquisition: 0x7F then a stream starting at 0x00
        do_reset();
        step(1'b1, 7'h7F);
        chk("brk_first_locked", int'(locked), 0);
        g = 21'h000080;
        for (int i = 0; i < 8; i++) begin
            good();
            chk($sformatf("brk_locked[%0d]", i), int'(locked), (i == 7) ? 1 : 0);
        end
        chk("brk_expected", int'(expected), int'(g[6:0]));
        chk("brk_no_mm", mm_seen, 0);

        // idle gaps of 1..5 cycles between valid samples
        do_reset();
        g = 21'h1FFFFF;
        for (int i = 0; i < 12; i++) begin
            good();
            if (i < 8) chk($sformatf("gap_locked[%0d]", i), int'(locked), (i == 7) ? 1 : 0);
            for (int k = 0; k <= i % 5; k++) step(1'b0, 7'(8'h2A + k));
        end
        chk("gap_locked_hold", int'(locked), 1);
        chk("gap_no_mm", mm_seen, 0);

        // err_count=5 while locked, then asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) begin
            if (i > 0) good();
            bad(1'b0);
        end
        chk("pre_rst_err", int'(err_count), err_exp(5));
        chk("pre_rst_mm", int'(mismatch), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_mm", int'(mismatch), 0);
        chk("async_rst_err", int'(err_count), 0);
        chk("async_rst_expected", int'(expected), 0);
        @(negedge clk);
        resetn = 1'b1;
        n_err = 0;
        mm_seen = 0;
        for (int i = 0; i < 8; i++) begin
            good();
            chk($sformatf("post_rst_locked[%0d]", i), int'(locked), (i == 7) ? 1 : 0);
        end

        // 300 forced mismatches, interleaved so lock is held
        for (int i = 0; i < 300; i++) begin
            bad(1'b0);
            good();
        end
        chk("sat_locked", int'(locked), 1);
        chk("sat_mm_count", mm_seen, 300);
        chk("sat_err", int'(err_count), err_exp(n_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
